// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bridge: FSM encoding, access size codes,
// default kseg0/kseg1 physical mask and the alignment helper.
package dmem_pkg;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADDR = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] DROP = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [31:0] PHYS_MASK_DEFAULT = 32'h1FFF_FFFF;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } busReq_t;

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    case (size)
      SZ_HALF: isMisaligned = addrLo[0];
      SZ_WORD: isMisaligned = (addrLo != 2'b00);
      default: isMisaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_addr_xlate.sv
// Fixed-mapping virtual-to-physical translation: kseg0/kseg1 are masked down,
// every other segment passes through unchanged.
module dmem_addr_xlate
  import dmem_pkg::*;
#(
  parameter logic [31:0] PHYS_MASK = PHYS_MASK_DEFAULT
) (
  input  logic [31:0] vAddr,
  output logic [31:0] pAddr
);

  // Unmapped kernel segments share the 2'b10 top bits.
  always_comb begin
    if (vAddr[31:30] == 2'b10) begin
      pAddr = vAddr & PHYS_MASK;
    end else begin
      pAddr = vAddr;
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// Memory-stage to bus bridge with a single outstanding transaction and flush handling.
// Optional alignment checking (adel/ades ports) is enabled by DMEM_BRIDGE_ALIGN_CHK_EN.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter logic [31:0] PHYS_MASK = PHYS_MASK_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [3:0]  mem_we,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        pipe_stall,
  input  logic        flush,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
`ifdef DMEM_BRIDGE_ALIGN_CHK_EN
  output logic        adel,
  output logic        ades,
`endif
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  logic [2:0]  state_r;
  logic [2:0]  stateNext_s;
  logic [31:0] physAddr_s;
  logic        misalign_s;
  logic        launch_s;
  logic        capture_s;
  busReq_t     launchReq_s;

  dmem_addr_xlate #(.PHYS_MASK(PHYS_MASK)) u_xlate (
    .vAddr (mem_addr),
    .pAddr (physAddr_s)
  );

`ifdef DMEM_BRIDGE_ALIGN_CHK_EN
  logic fault_s;
  assign misalign_s = isMisaligned(mem_size, mem_addr[1:0]);
  assign fault_s    = (state_r == IDLE) & req_en & ~flush & misalign_s;
`else
  assign misalign_s = 1'b0;
`endif

  assign launch_s  = (state_r == IDLE) & req_en & ~flush & ~misalign_s;
  assign capture_s = bus_data_ok & ~flush &
                     (((state_r == ADDR) & bus_addr_ok) | (state_r == DATA));
  assign mem_stall = rst & ((state_r == ADDR) | (state_r == DATA) |
                            (state_r == DROP) | launch_s);

  assign launchReq_s = '{wr: |mem_we, size: mem_size, wstrb: mem_we,
                         addr: physAddr_s, wdata: mem_wdata};

  // Next state; a flushed access that the bus has already accepted must still drain.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE: begin
        if (launch_s) stateNext_s = ADDR;
        else          stateNext_s = IDLE;
      end
      ADDR: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) stateNext_s = flush ? IDLE : DONE;
          else             stateNext_s = flush ? DROP : DATA;
        end else begin
          stateNext_s = flush ? IDLE : ADDR;
        end
      end
      DATA: begin
        if (bus_data_ok) stateNext_s = flush ? IDLE : DONE;
        else             stateNext_s = flush ? DROP : DATA;
      end
      DROP: begin
        if (bus_data_ok) stateNext_s = IDLE;
        else             stateNext_s = DROP;
      end
      DONE: begin
        if (pipe_stall) stateNext_s = DONE;
        else            stateNext_s = IDLE;
      end
      default: stateNext_s = IDLE;
    endcase
  end

  // State, bus request fields (latched at launch) and returned load data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_size  <= 2'd0;
      bus_wstrb <= 4'd0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      mem_rdata <= 32'd0;
    end else begin
      state_r <= stateNext_s;
      bus_req <= (stateNext_s == ADDR);
      if (launch_s) begin
        bus_wr    <= launchReq_s.wr;
        bus_size  <= launchReq_s.size;
        bus_wstrb <= launchReq_s.wstrb;
        bus_addr  <= launchReq_s.addr;
        bus_wdata <= launchReq_s.wdata;
      end
      if (capture_s) mem_rdata <= bus_rdata;
    end
  end

`ifdef DMEM_BRIDGE_ALIGN_CHK_EN
  // One-cycle address-error pulses; the faulting access never reaches the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adel <= 1'b0;
      ades <= 1'b0;
    end else begin
      adel <= fault_s & ~(|mem_we);
      ades <= fault_s & (|mem_we);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: transaction-level model, scripted bus slave,
// per-cycle compare plus directed literal checks.
module tb_dmem_bridge;

  logic        clk, rst, req_en, pipe_stall, flush;
  logic [3:0]  mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_stall, bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
`ifdef DMEM_BRIDGE_ALIGN_CHK_EN
  logic        adel, ades;
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  dmem_bridge dut (
    .clk(clk), .rst(rst), .req_en(req_en), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pipe_stall(pipe_stall), .flush(flush),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .bus_req(bus_req), .bus_wr(bus_wr),
    .bus_size(bus_size), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
`ifdef DMEM_BRIDGE_ALIGN_CHK_EN
    .adel(adel), .ades(ades),
`endif
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] phys(input logic [31:0] a);
    return (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
  endfunction

  function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
    return ALIGN_ON && ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00));
  endfunction

  // Transaction-level model: pending request, awaiting data (maybe killed), result held.
  bit          mPend, mWait, mKill, mHold;
  logic [31:0] mRdata, mAddr, mWdata;
  logic        mWr;
  logic [1:0]  mSize;
  logic [3:0]  mStrb;
`ifdef DMEM_BRIDGE_ALIGN_CHK_EN
  bit          mAdel, mAdes;
`endif

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mPend <= 1'b0; mWait <= 1'b0; mKill <= 1'b0; mHold <= 1'b0; mRdata <= 32'd0;
`ifdef DMEM_BRIDGE_ALIGN_CHK_EN
      mAdel <= 1'b0; mAdes <= 1'b0;
`endif
    end else begin
`ifdef DMEM_BRIDGE_ALIGN_CHK_EN
      mAdel <= 1'b0; mAdes <= 1'b0;
`endif
      if (mPend) begin
        if (bus_addr_ok) begin
          mPend <= 1'b0;
          if (bus_data_ok) begin
            if (!flush) begin mRdata <= bus_rdata; mHold <= 1'b1; end
          end else begin
            mWait <= 1'b1; mKill <= flush;
          end
        end else if (flush) mPend <= 1'b0;
      end else if (mWait) begin
        if (bus_data_ok) begin
          mWait <= 1'b0; mKill <= 1'b0;
          if (!mKill && !flush) begin mRdata <= bus_rdata; mHold <= 1'b1; end
        end else if (flush) mKill <= 1'b1;
      end else if (mHold) begin
        if (!pipe_stall) mHold <= 1'b0;
      end else if (req_en && !flush) begin
        if (misaligned(mem_size, mem_addr)) begin
`ifdef DMEM_BRIDGE_ALIGN_CHK_EN
          mAdel <= (mem_we == 4'd0); mAdes <= (mem_we != 4'd0);
`endif
        end else begin
          mPend <= 1'b1; mAddr <= phys(mem_addr); mWr <= (mem_we != 4'd0);
          mSize <= mem_size; mStrb <= mem_we; mWdata <= mem_wdata;
        end
      end
    end
  end

  function automatic bit expStall();
    bit idle = !(mPend || mWait || mHold);
    return mPend || mWait ||
           (rst && idle && req_en && !flush && !misaligned(mem_size, mem_addr));
  endfunction

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    check("busReq", 32'(bus_req), 32'(mPend));
    check("memStall", 32'(mem_stall), 32'(expStall()));
    check("memRdata", mem_rdata, mRdata);
    if (mPend) begin
      check("busAddr", bus_addr, mAddr);
      check("busWr", 32'(bus_wr), 32'(mWr));
      check("busSize", 32'(bus_size), 32'(mSize));
      check("busWstrb", 32'(bus_wstrb), 32'(mStrb));
      check("busWdata", bus_wdata, mWdata);
    end
`ifdef DMEM_BRIDGE_ALIGN_CHK_EN
    check("adel", 32'(adel), 32'(mAdel));
    check("ades", 32'(ades), 32'(mAdes));
`endif
  end

  // Scripted bus slave: accepts after respAddrDelay request cycles, answers
  // respDataDelay cycles later (0 = same cycle as the acceptance).
  int          respAddrDelay, respDataDelay, aCnt, dCnt, accepts;
  bit          respBusy;
  logic [31:0] respData, lastAddr, lastWdata;
  logic        lastWr;
  logic [3:0]  lastStrb;

  initial begin
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
    aCnt = 0; dCnt = 0; accepts = 0; respBusy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      if (!rst) begin
        aCnt = 0; respBusy = 1'b0;
      end else if (respBusy) begin
        dCnt++;
        if (dCnt >= respDataDelay) begin bus_data_ok = 1'b1; bus_rdata = respData; respBusy = 1'b0; end
      end else if (bus_req) begin
        if (aCnt >= respAddrDelay) begin
          bus_addr_ok = 1'b1; aCnt = 0; dCnt = 0; accepts++;
          lastAddr = bus_addr; lastWr = bus_wr; lastStrb = bus_wstrb; lastWdata = bus_wdata;
          if (respDataDelay == 0) begin bus_data_ok = 1'b1; bus_rdata = respData; end
          else respBusy = 1'b1;
        end else aCnt++;
      end else aCnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic access(input logic [3:0] we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output int n);
    mem_we = we; mem_size = sz; mem_addr = a; mem_wdata = wd; req_en = 1'b1;
    n = 0;
    #1;
    while (mem_stall && n < 60) begin n++; tick(); #1; end
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL accessTimeout got %0d stall cycles expected fewer than 60", n);
    end
  endtask

  int n, acc0;

  initial begin
    rst = 1'b0; req_en = 1'b0; mem_we = 4'd0; mem_size = 2'd0; mem_addr = 32'd0;
    mem_wdata = 32'd0; pipe_stall = 1'b0; flush = 1'b0;
    respAddrDelay = 0; respDataDelay = 1; respData = 32'd0;
    repeat (3) tick();
    #1;
    check("rstBusAddr", bus_addr, 32'd0);
    check("rstBusWr", 32'(bus_wr), 32'd0);
    check("rstBusWstrb", 32'(bus_wstrb), 32'd0);
    check("rstBusWdata", bus_wdata, 32'd0);
    check("rstRdata", mem_rdata, 32'd0);
    rst = 1'b1;
    tick();

    // Zero-wait word load from kseg0.
    respData = 32'hDEAD_BEEF; acc0 = accepts;
    access(4'd0, 2'd2, 32'h8000_0010, 32'd0, n);
    check("t1StallAfterLaunch", n - 1, 32'd2);
    check("t1Rdata", mem_rdata, 32'hDEAD_BEEF);
    check("t1ModelRdata", mRdata, 32'hDEAD_BEEF);
    check("t1BusAddr", lastAddr, 32'h0000_0010);
    check("t1BusWr", 32'(lastWr), 32'd0);
    check("t1Accepts", accepts - acc0, 32'd1);
    req_en = 1'b0; tick();

    // Byte store into kseg1.
    respData = 32'h1111_2222; acc0 = accepts;
    access(4'b0100, 2'd0, 32'hA000_0005, 32'hABAB_ABAB, n);
    check("t2BusWr", 32'(lastWr), 32'd1);
    check("t2BusWstrb", 32'(lastStrb), 32'h4);
    check("t2BusAddr", lastAddr, 32'h0000_0005);
    check("t2BusWdata", lastWdata, 32'hABAB_ABAB);
    check("t2Accepts", accepts - acc0, 32'd1);
    req_en = 1'b0; tick();

    // Slow bus: 3 waiting request cycles, data 2 cycles after acceptance.
    respAddrDelay = 3; respDataDelay = 2; respData = 32'hCAFE_0001; acc0 = accepts;
    access(4'd0, 2'd1, 32'h0000_1234, 32'd0, n);
    check("t3StallCycles", n, 32'd7);
    check("t3Rdata", mem_rdata, 32'hCAFE_0001);
    check("t3BusAddr", lastAddr, 32'h0000_1234);
    check("t3Accepts", accepts - acc0, 32'd1);
    req_en = 1'b0; tick();

    // Flush while waiting in DATA; late data must be dropped.
    respAddrDelay = 0; respDataDelay = 3; respData = 32'hBAD0_BAD0; acc0 = accepts;
    mem_we = 4'd0; mem_size = 2'd2; mem_addr = 32'hC000_0100; req_en = 1'b1;
    tick(); tick();
    flush = 1'b1; req_en = 1'b0; tick(); flush = 1'b0;
    repeat (4) tick();
    #1;
    check("t4RdataKept", mem_rdata, 32'hCAFE_0001);
    check("t4Accepts", accepts - acc0, 32'd1);
    check("t4NoReissue", 32'(bus_req), 32'd0);
    check("t4BusAddr", lastAddr, 32'hC000_0100);

    // Flush coinciding with data_ok in DATA.
    respDataDelay = 1; respData = 32'h5555_AAAA; acc0 = accepts;
    req_en = 1'b1; tick(); tick();
    flush = 1'b1; req_en = 1'b0; tick(); flush = 1'b0; tick();
    #1;
    check("t5RdataKept", mem_rdata, 32'hCAFE_0001);
    check("t5Accepts", accepts - acc0, 32'd1);

    // Flush in ADDR before acceptance: request withdrawn.
    respAddrDelay = 5; acc0 = accepts;
    req_en = 1'b1; tick();
    flush = 1'b1; req_en = 1'b0; tick(); flush = 1'b0;
    #1;
    check("t6Dropped", 32'(bus_req), 32'd0);
    repeat (6) tick();
    check("t6Accepts", accepts - acc0, 32'd0);

    // Held in DONE by pipe_stall with req_en still high.
    respAddrDelay = 0; respDataDelay = 1; respData = 32'h0BAD_F00D; acc0 = accepts;
    access(4'd0, 2'd2, 32'h0000_0040, 32'd0, n);
    pipe_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      check("t7NoSecondReq", 32'(bus_req), 32'd0);
      check("t7RdataHeld", mem_rdata, 32'h0BAD_F00D);
    end
    pipe_stall = 1'b0; req_en = 1'b0; tick();
    check("t7Accepts", accepts - acc0, 32'd1);

    // Reset in the middle of a transaction.
    respAddrDelay = 10;
    mem_addr = 32'h0000_0080; req_en = 1'b1; tick(); tick();
    #1; rst = 1'b0; #1;
    check("t8RstBusReq", 32'(bus_req), 32'd0);
    check("t8RstStall", 32'(mem_stall), 32'd0);
    check("t8RstRdata", mem_rdata, 32'd0);
    req_en = 1'b0; tick(); rst = 1'b1; tick();
    respAddrDelay = 0; respData = 32'h1234_5678; acc0 = accepts;
    access(4'd0, 2'd2, 32'h9FFF_FFFC, 32'd0, n);
    check("t8Recover", mem_rdata, 32'h1234_5678);
    check("t8BusAddr", lastAddr, 32'h1FFF_FFFC);
    req_en = 1'b0; tick();

    // Misaligned word load.
    acc0 = accepts; respData = 32'h7777_0000;
`ifdef DMEM_BRIDGE_ALIGN_CHK_EN
    mem_we = 4'd0; mem_size = 2'd2; mem_addr = 32'h8000_0002; req_en = 1'b1;
    #1; check("t9NoStall", 32'(mem_stall), 32'd0);
    tick(); req_en = 1'b0; #1;
    check("t9AdelPulse", 32'(adel), 32'd1);
    tick(); #1;
    check("t9AdelOnce", 32'(adel), 32'd0);
    mem_we = 4'b0110; mem_size = 2'd1; mem_addr = 32'h0000_0101; req_en = 1'b1;
    tick(); req_en = 1'b0; #1;
    check("t9AdesPulse", 32'(ades), 32'd1);
    repeat (3) tick();
    check("t9Accepts", accepts - acc0, 32'd0);
`else
    access(4'd0, 2'd2, 32'h8000_0002, 32'd0, n);
    check("t9Issued", accepts - acc0, 32'd1);
    check("t9BusAddr", lastAddr, 32'h0000_0002);
    req_en = 1'b0; tick();
`endif
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter PHYS_MASK, default 32'h1FFF_FFFF, is the mask applied to kseg0/kseg1 addresses.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 req_en  in  1  memory stage holds a valid load or store.
REQ-005 mem_we  in  4  byte write enables; nonzero means store, zero means load.
REQ-006 mem_size  in  2  access size: 0 = byte, 1 = half, 2 = word.
REQ-007 mem_addr  in  32  virtual byte address.
REQ-008 mem_wdata  in  32  lane-replicated store data.
REQ-009 pipe_stall  in  1  another hazard source is holding the memory stage.
REQ-010 flush  in  1  kill the current memory-stage instruction.
REQ-011 mem_rdata  out  32  load data returned to the pipeline.
REQ-012 mem_stall  out  1  freeze the pipeline; feeds the hazard unit.
REQ-013 bus_req  out  1  bus request valid.
REQ-014 bus_wr  out  1  1 = write, 0 = read.
REQ-015 bus_size  out  2  copy of mem_size.
REQ-016 bus_wstrb  out  4  copy of mem_we.
REQ-017 bus_addr  out  32  physical address.
REQ-018 bus_wdata  out  32  write data.
REQ-019 bus_addr_ok  in  1  bus accepted the request this cycle.
REQ-020 bus_data_ok  in  1  bus read data is valid, or the write completed, this cycle.
REQ-021 bus_rdata  in  32  bus read data.

Function
REQ-022 The FSM states shall be IDLE, ADDR, DATA, DROP and DONE.
REQ-023 IDLE shall go to ADDR when req_en=1, flush=0 and no alignment fault exists.
REQ-024 In ADDR, bus_req=1 and the bus fields shall come from registers latched on entry and held stable until addr_ok.
REQ-025 On bus_addr_ok, ADDR shall go to DATA; a same-cycle bus_data_ok shall take ADDR directly to DONE.
REQ-026 On bus_data_ok, DATA shall go to DONE and capture bus_rdata into mem_rdata.
REQ-027 DONE shall hold mem_rdata and go to IDLE at the first cycle with pipe_stall=0.
REQ-028 DONE shall not issue a new request, even if req_en remains 1.
REQ-029 mem_stall shall be 1 in ADDR, DATA and DROP, and in IDLE whenever a request is being launched; it shall be 0 otherwise.
REQ-030 Read latency shall be at least 2 cycles from launch to DONE.
REQ-031 Zero-wait bus: addr_ok in the first ADDR cycle and data_ok in the next cycle.
REQ-032 Flush in ADDR with bus_addr_ok=0 shall drop the request and return to IDLE next cycle.
REQ-033 Flush in ADDR with bus_addr_ok=1 shall go to DROP.
REQ-034 Flush in DATA shall go to DROP.
REQ-035 DROP shall wait for bus_data_ok, discard the data, leave mem_rdata unchanged and go to IDLE.
REQ-036 If flush and bus_data_ok occur together in DATA, the state shall go to IDLE with data discarded.
REQ-037 Address translation: if mem_addr[31:30]=2'b10, bus_addr = mem_addr & PHYS_MASK; otherwise bus_addr = mem_addr.
REQ-038 At most one outstanding bus transaction shall exist.

Reset
REQ-039 Reset shall force state IDLE, all bus outputs to 0, mem_rdata to 0, mem_stall to 0 and any fault flags to 0.
REQ-040 Reset mid-transaction shall abandon it without waiting for bus_data_ok.

Configuration
REQ-041 DMEM_BRIDGE_ALIGN_CHK_EN shall control alignment checking.
REQ-042 With DMEM_BRIDGE_ALIGN_CHK_EN defined, ports adel (out, 1) and ades (out, 1) shall exist.
REQ-043 A misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) shall issue no bus request.
REQ-044 A misaligned access shall pulse adel (load) or ades (store) for one cycle and shall not stall.
REQ-045 Without DMEM_BRIDGE_ALIGN_CHK_EN, the adel/ades ports shall be absent and all accesses shall be issued.

Structure
REQ-046 The state encoding, size codes and the default PHYS_MASK shall live in shared package dmem_pkg.
REQ-047 Translation logic shall be a sub-module, dmem_addr_xlate (combinational).

Verification
REQ-048 Load, zero-wait: addr 32'h8000_0010, size 2, rdata 32'hDEAD_BEEF -> bus_addr 32'h0000_0010, mem_stall high 2 cycles, mem_rdata 32'hDEAD_BEEF.
REQ-049 Store, byte: mem_we 4'b0100, addr 32'hA000_0005, size 0 -> bus_wr=1, bus_wstrb 4'b0100, bus_addr 32'h0000_0005.
REQ-050 Bus delays: addr_ok after 3 cycles, data_ok after 2 more -> bus fields stable throughout, exactly one bus_req acceptance.
REQ-051 Flush in DATA, then data_ok -> mem_rdata unchanged, IDLE, no re-issue.
REQ-052 pipe_stall held 4 cycles in DONE with req_en=1 -> no second bus_req; mem_rdata held.
REQ-053 ALIGN_CHK_EN: word load at 32'h8000_0002 -> adel pulses once, bus_req stays 0, mem_stall stays 0.
